// File: rtl/pc_seq_lut.sv
// Program counter sequencer with a writable jump table (absolute/relative entries).
// Optional link register for call/return is enabled by defining PC_SEQ_LUT_LINK_EN.
module pc_seq_lut #(
    parameter int PC_W      = 8,
    parameter int LUT_DEPTH = 8,
    localparam int PTR_W    = $clog2(LUT_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             halt_req,
    input  logic             branch_en,
    input  logic [PTR_W-1:0] ptr,
    input  logic             lut_we,
    input  logic [PTR_W-1:0] lut_waddr,
    input  logic [PC_W-1:0]  lut_wdata,
    input  logic             lut_wabs,
    input  logic             call_en,
    input  logic             ret_en,
    output logic [PC_W-1:0]  pc,
    output logic             running,
    output logic             halted
);

    localparam logic [PC_W-1:0] ONE = PC_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } state_t;

    state_t          state, state_n;
    logic [PC_W-1:0] pc_n;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] rd_tgt;
    logic [PC_W-1:0] br_pc;

    logic [PC_W-1:0]      tgt [LUT_DEPTH];
    logic [LUT_DEPTH-1:0] absm;

    // Reset leaves every entry as "relative +1", i.e. a plain step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                tgt[i] <= ONE;
            end
            absm <= '0;
        end else if (lut_we) begin
            tgt[lut_waddr]  <= lut_wdata;
            absm[lut_waddr] <= lut_wabs;
        end
    end

    assign pc_inc = pc + ONE;
    assign rd_tgt = tgt[ptr];
    assign br_pc  = absm[ptr] ? rd_tgt : pc + rd_tgt;

`ifdef PC_SEQ_LUT_LINK_EN
    logic [PC_W-1:0] link, link_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            link <= '0;
        end else begin
            link <= link_n;
        end
    end
`else
    logic unused_link_ctl;
    assign unused_link_ctl = call_en ^ ret_en;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
`ifdef PC_SEQ_LUT_LINK_EN
        link_n  = link;
`endif
        if (start) begin
            state_n = RUN;
            pc_n    = '0;
        end else begin
            unique case (state)
                IDLE: ;
                RUN: begin
                    if (halt_req) begin
                        state_n = HALT;
`ifdef PC_SEQ_LUT_LINK_EN
                    end else if (ret_en) begin
                        pc_n = link;
`endif
                    end else if (branch_en) begin
                        pc_n = br_pc;
`ifdef PC_SEQ_LUT_LINK_EN
                        if (call_en) begin
                            link_n = pc_inc;
                        end
`endif
                    end else begin
                        pc_n = pc_inc;
                    end
                end
                HALT: ;
                default: state_n = IDLE;
            endcase
        end
    end

    assign running = (state == RUN);
    assign halted  = (state == HALT);

endmodule

// File: tb/tb_pc_seq_lut.sv
// Self-checking bench for pc_seq_lut: directed scenarios plus a
// randomized run against a behavioural program-counter model.
module tb_pc_seq_lut;

    logic       clk;
    logic       rst_n;
    logic       start, halt_req, branch_en;
    logic [2:0] ptr;
    logic       lut_we;
    logic [2:0] lut_waddr;
    logic [7:0] lut_wdata;
    logic       lut_wabs;
    logic       call_en, ret_en;
    logic [7:0] pc;
    logic       running, halted;

    int errors = 0;
    int checks = 0;

    // Behavioural model: 0 = idle, 1 = run, 2 = halt
    int         m_st;
    logic [7:0] m_pc, m_link;
    logic [7:0] m_tgt [8];
    bit         m_abs [8];

    pc_seq_lut #(.PC_W(8), .LUT_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
        .branch_en(branch_en), .ptr(ptr), .lut_we(lut_we),
        .lut_waddr(lut_waddr), .lut_wdata(lut_wdata), .lut_wabs(lut_wabs),
        .call_en(call_en), .ret_en(ret_en), .pc(pc),
        .running(running), .halted(halted)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic model_reset;
        m_st = 0; m_pc = 0; m_link = 0;
        for (int i = 0; i < 8; i++) begin
            m_tgt[i] = 8'd1; m_abs[i] = 0;
        end
    endtask

    task automatic clear_inputs;
        start = 0; halt_req = 0; branch_en = 0; ptr = 0;
        lut_we = 0; lut_waddr = 0; lut_wdata = 0; lut_wabs = 0;
        call_en = 0; ret_en = 0;
    endtask

    // Advance the model from the current inputs, then one clock.
    task automatic cycle;
        int ns; logic [7:0] npc, nl;
        ns = m_st; npc = m_pc; nl = m_link;
        if (start) begin
            ns = 1; npc = 0;
        end else if (m_st == 1) begin
            if (halt_req) ns = 2;
`ifdef PC_SEQ_LUT_LINK_EN
            else if (ret_en) npc = m_link;
`endif
            else if (branch_en) begin
                npc = m_abs[ptr] ? m_tgt[ptr] : 8'(m_pc + m_tgt[ptr]);
`ifdef PC_SEQ_LUT_LINK_EN
                if (call_en) nl = m_pc + 8'd1;
`endif
            end
            else npc = m_pc + 8'd1;
        end
        if (lut_we) begin
            m_tgt[lut_waddr] = lut_wdata; m_abs[lut_waddr] = lut_wabs;
        end
        m_st = ns; m_pc = npc; m_link = nl;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1; clear_inputs(); model_reset();
        #2 rst_n = 0; #1;
        checks++; if (pc !== 8'd0) begin errors++; $display("FAIL reset_pc got=%0d exp=0", pc); end
        checks++; if (running !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", running, halted); end
        @(posedge clk); #1 rst_n = 1;
        cycle(); cycle();
        checks++; if (pc !== 8'd0 || running !== 1'b0) begin errors++; $display("FAIL idle_hold pc=%0d run=%b exp=0,0", pc, running); end
    endtask

    task automatic test_seq;
        start = 1; cycle(); start = 0;
        checks++; if (pc !== 8'd0 || running !== 1'b1) begin errors++; $display("FAIL start pc=%0d run=%b exp=0,1", pc, running); end
        for (int i = 1; i <= 5; i++) begin
            cycle();
            checks++; if (pc !== 8'(i)) begin errors++; $display("FAIL seq pc=%0d exp=%0d", pc, i); end
        end
    endtask

    task automatic test_branch;
        start = 1; lut_we = 1; lut_waddr = 1; lut_wdata = 8'd8; lut_wabs = 1;
        cycle(); start = 0;
        lut_waddr = 2; lut_wdata = 8'hFD; lut_wabs = 0;
        cycle(); lut_we = 0;
        repeat (4) cycle();
        checks++; if (pc !== 8'd5) begin errors++; $display("FAIL br_pre pc=%0d exp=5", pc); end
        branch_en = 1; ptr = 1; cycle();
        checks++; if (pc !== 8'd8) begin errors++; $display("FAIL br_abs pc=%0d exp=8", pc); end
        ptr = 2; cycle();
        checks++; if (pc !== 8'd5) begin errors++; $display("FAIL br_rel pc=%0d exp=5", pc); end
        branch_en = 0;
    endtask

    task automatic test_wrap;
        lut_we = 1; lut_waddr = 0; lut_wdata = 8'd254; lut_wabs = 1; cycle();
        lut_waddr = 4; lut_wdata = 8'd4; lut_wabs = 0; cycle();
        lut_we = 0; branch_en = 1; ptr = 0; cycle();
        checks++; if (pc !== 8'd254) begin errors++; $display("FAIL wrap_set pc=%0d exp=254", pc); end
        ptr = 4; cycle();
        checks++; if (pc !== 8'd2) begin errors++; $display("FAIL wrap_rel pc=%0d exp=2", pc); end
        ptr = 0; cycle(); branch_en = 0; cycle();
        checks++; if (pc !== 8'd255) begin errors++; $display("FAIL wrap_255 pc=%0d exp=255", pc); end
        cycle();
        checks++; if (pc !== 8'd0) begin errors++; $display("FAIL wrap_seq pc=%0d exp=0", pc); end
    endtask

    task automatic test_halt;
        lut_we = 1; lut_waddr = 5; lut_wdata = 8'd7; lut_wabs = 1; cycle();
        lut_we = 0; branch_en = 1; ptr = 5; cycle();
        checks++; if (pc !== 8'd7) begin errors++; $display("FAIL halt_pre pc=%0d exp=7", pc); end
        halt_req = 1; ptr = 1; cycle(); branch_en = 0;
        checks++; if (halted !== 1'b1 || running !== 1'b0 || pc !== 8'd7) begin errors++; $display("FAIL halt_enter pc=%0d h=%b r=%b exp=7,1,0", pc, halted, running); end
        lut_we = 1; lut_waddr = 6; lut_wdata = 8'd40; lut_wabs = 1;
        for (int i = 0; i < 3; i++) begin
            cycle(); lut_we = 0;
            checks++; if (pc !== 8'd7 || halted !== 1'b1) begin errors++; $display("FAIL halt_hold pc=%0d h=%b exp=7,1", pc, halted); end
        end
        halt_req = 0; start = 1; cycle(); start = 0;
        checks++; if (pc !== 8'd0 || running !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL halt_restart pc=%0d r=%b h=%b exp=0,1,0", pc, running, halted); end
        branch_en = 1; ptr = 6; cycle(); branch_en = 0;
        checks++; if (pc !== 8'd40) begin errors++; $display("FAIL halt_write pc=%0d exp=40", pc); end
    endtask

    task automatic test_same_cycle;
        start = 1; cycle(); start = 0;
        repeat (4) cycle();
        checks++; if (pc !== 8'd4) begin errors++; $display("FAIL same_pre pc=%0d exp=4", pc); end
        lut_we = 1; lut_waddr = 3; lut_wdata = 8'd20; lut_wabs = 1;
        branch_en = 1; ptr = 3; cycle(); lut_we = 0;
        checks++; if (pc !== 8'd5) begin errors++; $display("FAIL same_old pc=%0d exp=5", pc); end
        cycle(); branch_en = 0;
        checks++; if (pc !== 8'd20) begin errors++; $display("FAIL same_new pc=%0d exp=20", pc); end
    endtask

    task automatic test_link;
        logic [7:0] exp_ret;
        start = 1; lut_we = 1; lut_waddr = 7; lut_wdata = 8'd30; lut_wabs = 1;
        cycle(); start = 0; lut_we = 0;
        repeat (10) cycle();
        checks++; if (pc !== 8'd10) begin errors++; $display("FAIL link_pre pc=%0d exp=10", pc); end
        call_en = 1; branch_en = 1; ptr = 7; cycle(); call_en = 0; branch_en = 0;
        checks++; if (pc !== 8'd30) begin errors++; $display("FAIL link_call pc=%0d exp=30", pc); end
        cycle(); cycle();
        checks++; if (pc !== 8'd32) begin errors++; $display("FAIL link_mid pc=%0d exp=32", pc); end
        ret_en = 1; cycle(); ret_en = 0;
`ifdef PC_SEQ_LUT_LINK_EN
        exp_ret = 8'd11;
`else
        exp_ret = 8'd33;
`endif
        checks++; if (pc !== exp_ret) begin errors++; $display("FAIL link_ret pc=%0d exp=%0d", pc, exp_ret); end
    endtask

    task automatic test_async_reset;
        start = 1; cycle(); start = 0;
        repeat (3) cycle();
        #2 rst_n = 0; #1;
        model_reset();
        checks++; if (pc !== 8'd0 || running !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL async_rst pc=%0d r=%b h=%b exp=0,0,0", pc, running, halted); end
        @(posedge clk); #1 rst_n = 1;
        cycle();
        checks++; if (pc !== 8'd0 || running !== 1'b0) begin errors++; $display("FAIL async_wait pc=%0d r=%b exp=0,0", pc, running); end
        start = 1; cycle(); start = 0;
        branch_en = 1; ptr = 1; cycle(); branch_en = 0;
        checks++; if (pc !== 8'd1) begin errors++; $display("FAIL async_lut pc=%0d exp=1", pc); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            start     = ($urandom_range(0, 19) == 0);
            halt_req  = ($urandom_range(0, 15) == 0);
            branch_en = ($urandom_range(0, 2) == 0);
            ptr       = 3'($urandom);
            lut_we    = ($urandom_range(0, 3) == 0);
            lut_waddr = 3'($urandom);
            lut_wdata = 8'($urandom);
            lut_wabs  = 1'($urandom);
            call_en   = ($urandom_range(0, 2) == 0);
            ret_en    = ($urandom_range(0, 7) == 0);
            cycle();
            checks++;
            if (pc !== m_pc || running !== (m_st == 1) || halted !== (m_st == 2)) begin
                errors++;
                $display("FAIL rand[%0d] pc=%0d r=%b h=%b exp=%0d,%0b,%0b", i, pc, running, halted, m_pc, m_st == 1, m_st == 2);
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_seq();
        test_branch();
        test_wrap();
        test_halt();
        test_same_cycle();
        test_link();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
